// File: rtl/phase_mon_pkg.sv
// Shared types and helpers for the phase convergence monitor.
// Record layout: {inject, preempt, timeout, lat[7:0]}.
package phase_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int REC_W   = 11;
  localparam int LAT_LSB = 0;
  localparam int TO_BIT  = 8;
  localparam int PRE_BIT = 9;
  localparam int INJ_BIT = 10;

  // Shortest distance between two phases on the 256-step circle.
  function automatic logic [7:0] circ_dist8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] d;
    logic [7:0] e;
    d = a - b;
    e = b - a;
    return (d < e) ? d : e;
  endfunction

endpackage

// File: rtl/convergence_tracker_if.sv
// History FIFO read port: pop request plus show-ahead head record.
// master is the reader, slave is the tracker.
interface convergence_tracker_if;
  import phase_mon_pkg::*;

  logic             hist_rd;
  logic [REC_W-1:0] hist_data;
  logic             hist_empty;
  logic             hist_full;

  modport master (
    output hist_rd,
    input  hist_data,
    input  hist_empty,
    input  hist_full
  );

  modport slave (
    input  hist_rd,
    output hist_data,
    output hist_empty,
    output hist_full
  );

endinterface

// File: rtl/latency_hist_fifo.sv
// Show-ahead history FIFO; a push into a full FIFO is dropped
// unless a pop frees the slot on the same clock.
module latency_hist_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_pop;
  logic         do_push;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];

  // Storage, pointers and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + ONE;
      end
      if (do_pop) rp <= rp + ONE;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/convergence_tracker.sv
// Measures gamma cycles from a phase jump until the predictor
// error settles, logging one record per jump into a FIFO.
module convergence_tracker
  import phase_mon_pkg::*;
#(
  parameter logic [7:0] ERR_THRESH  = 8'd3,
  parameter logic [7:0] TRANS_DELTA = 8'd16,
  parameter logic [7:0] MIN_LAT     = 8'd2,
  parameter logic [7:0] HOLD_CYC    = 8'd1,
  parameter logic [7:0] MAX_CYC     = 8'd12,
  parameter int         HIST_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cycle_start,
  input  logic [7:0] actual_phase,
  input  logic       fired,
  input  logic [7:0] error_mag,
  input  logic       error_valid,
  input  logic       force_valid,
  output logic [1:0] state,
  output logic       lat_valid,
  output logic [7:0] latency,
  output logic [7:0] trans_count,
  convergence_tracker_if.slave hist,
  output logic       overflow
);

  state_t     st, st_n;
  logic [7:0] ph_q, err_q, prev_q;
  logic       ph_seen, err_seen, prev_vld;
  logic [7:0] cnt, cnt_n, hold, hold_n;
  logic [7:0] run_start, run_start_n;
  logic [7:0] lat, lat_n;
  logic       inj, inj_n, pend, pend_n;
  logic       rec_to, rec_to_n;
  logic       rec_pre, rec_pre_n;
  logic       rec_inj, rec_inj_n;
  logic       f_eff, e_eff, trans, in_thr;
  logic [7:0] p_eff, e_val, cnt_inc;

  // Same-clock samples at the boundary belong to the ending cycle.
  assign f_eff   = fired | ph_seen;
  assign p_eff   = fired ? actual_phase : ph_q;
  assign e_eff   = error_valid | err_seen;
  assign e_val   = error_valid ? error_mag : err_q;
  assign trans   = cycle_start && f_eff && prev_vld &&
                   (circ_dist8(p_eff, prev_q) > TRANS_DELTA);
  assign cnt_inc = (cnt == 8'hff) ? cnt : cnt + 8'd1;
  assign in_thr  = e_eff && (e_val <= ERR_THRESH) &&
                   (cnt_inc >= MIN_LAT);

  assign state     = st;
  assign lat_valid = (st == DONE);
  assign latency   = lat;

  // In-cycle samplers and phase reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q     <= '0;
      err_q    <= '0;
      ph_seen  <= 1'b0;
      err_seen <= 1'b0;
      prev_q   <= '0;
      prev_vld <= 1'b0;
    end else if (cycle_start) begin
      ph_q     <= '0;
      err_q    <= '0;
      ph_seen  <= 1'b0;
      err_seen <= 1'b0;
      if (f_eff) begin
        prev_q   <= p_eff;
        prev_vld <= 1'b1;
      end
    end else begin
      if (fired) begin
        ph_q    <= actual_phase;
        ph_seen <= 1'b1;
      end
      if (error_valid) begin
        err_q    <= error_mag;
        err_seen <= 1'b1;
      end
    end
  end

  // Saturating transition counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trans_count <= '0;
    else if (trans && trans_count != 8'hff)
      trans_count <= trans_count + 8'd1;
  end

  // FSM and measurement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      cnt       <= '0;
      hold      <= '0;
      run_start <= '0;
      lat       <= '0;
      inj       <= 1'b0;
      pend      <= 1'b0;
      rec_to    <= 1'b0;
      rec_pre   <= 1'b0;
      rec_inj   <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      run_start <= run_start_n;
      lat       <= lat_n;
      inj       <= inj_n;
      pend      <= pend_n;
      rec_to    <= rec_to_n;
      rec_pre   <= rec_pre_n;
      rec_inj   <= rec_inj_n;
    end
  end

  // Next-state and measurement update.
  always_comb begin
    st_n        = st;
    cnt_n       = cnt;
    hold_n      = hold;
    run_start_n = run_start;
    lat_n       = lat;
    inj_n       = inj;
    pend_n      = pend;
    rec_to_n    = rec_to;
    rec_pre_n   = rec_pre;
    rec_inj_n   = rec_inj;
    unique case (st)
      IDLE: begin
        if (trans) begin
          st_n   = TRACK;
          cnt_n  = '0;
          hold_n = '0;
          inj_n  = 1'b0;
        end
      end
      TRACK: begin
        if (force_valid) inj_n = 1'b1;
        if (cycle_start) begin
          cnt_n  = cnt_inc;
          hold_n = in_thr ? hold + 8'd1 : 8'd0;
          if (in_thr && hold == 8'd0) run_start_n = cnt_inc;
          rec_inj_n = inj | force_valid;
          if (trans) begin
            st_n      = DONE;
            lat_n     = cnt_inc;
            rec_to_n  = 1'b0;
            rec_pre_n = 1'b1;
            pend_n    = 1'b1;
            cnt_n     = '0;
            hold_n    = '0;
            inj_n     = 1'b0;
          end else if (hold_n == HOLD_CYC) begin
            st_n      = DONE;
            lat_n     = run_start_n;
            rec_to_n  = 1'b0;
            rec_pre_n = 1'b0;
          end else if (cnt_inc == MAX_CYC) begin
            st_n      = DONE;
            lat_n     = MAX_CYC;
            rec_to_n  = 1'b1;
            rec_pre_n = 1'b0;
          end
        end
      end
      DONE: begin
        st_n   = pend ? TRACK : IDLE;
        pend_n = 1'b0;
        if (trans) begin
          st_n   = TRACK;
          cnt_n  = '0;
          hold_n = '0;
          inj_n  = 1'b0;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  latency_hist_fifo #(
    .DEPTH (HIST_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (st == DONE),
    .din      ({rec_inj, rec_pre, rec_to, lat}),
    .pop      (hist.hist_rd),
    .dout     (hist.hist_data),
    .empty    (hist.hist_empty),
    .full     (hist.hist_full),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_convergence_tracker.sv
// Directed bench for convergence_tracker.
// Each gamma cycle is four clocks; cycle_start on the last.
module tb_convergence_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cycle_start = 1'b0;
  logic [7:0] actual_phase = '0;
  logic       fired = 1'b0;
  logic [7:0] error_mag = '0;
  logic       error_valid = 1'b0;
  logic       force_valid = 1'b0;
  logic [1:0] state;
  logic       lat_valid;
  logic [7:0] latency;
  logic [7:0] trans_count;
  logic       overflow;
  int         errs = 0;
  int         checks = 0;

  convergence_tracker_if hist ();

  convergence_tracker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cycle_start  (cycle_start),
    .actual_phase (actual_phase),
    .fired        (fired),
    .error_mag    (error_mag),
    .error_valid  (error_valid),
    .force_valid  (force_valid),
    .state        (state),
    .lat_valid    (lat_valid),
    .latency      (latency),
    .trans_count  (trans_count),
    .hist         (hist),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic gcycle(
    input logic       fi,
    input logic [7:0] ph,
    input logic       ev,
    input logic [7:0] er,
    input logic       fv
  );
    @(posedge clk) #1;
    fired = fi; actual_phase = ph;
    error_valid = ev; error_mag = er;
    force_valid = fv;
    @(posedge clk) #1;
    fired = 0; error_valid = 0; force_valid = 0;
    @(posedge clk) #1;
    cycle_start = 1;
    @(posedge clk) #1;
    cycle_start = 0;
  endtask

  task automatic do_reset();
    hist.hist_rd = 0;
    @(posedge clk) #1 rst_n = 0;
    @(posedge clk) #1 rst_n = 1;
  endtask

  task automatic pop();
    hist.hist_rd = 1;
    @(posedge clk) #1;
    hist.hist_rd = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    hist.hist_rd = 0;
    @(posedge clk) #1;
    checks++;
    if (state !== 2'd0) begin
      errs++; $display("FAIL rst_state got=%0d exp=0", state);
    end
    checks++;
    if (lat_valid !== 1'b0 || latency !== 8'd0) begin
      errs++;
      $display("FAIL rst_lat got=%b/%0d exp=0/0", lat_valid, latency);
    end
    checks++;
    if (trans_count !== 8'd0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL rst_cnt got=%0d/%b exp=0/0", trans_count, overflow);
    end
    checks++;
    if (hist.hist_empty !== 1'b1 || hist.hist_full !== 1'b0 ||
        hist.hist_data !== 11'h000) begin
      errs++;
      $display("FAIL rst_fifo got=%b/%b/%h exp=1/0/000",
               hist.hist_empty, hist.hist_full, hist.hist_data);
    end
    rst_n = 1;
    gcycle(1, 8'd1, 0, 8'd0, 0);
    checks++;
    if (trans_count !== 8'd0 || state !== 2'd0) begin
      errs++;
      $display("FAIL rst_first_fire got=%0d/%0d exp=0/0", trans_count, state);
    end
  endtask

  task automatic test_converge();
    logic [7:0] ev [5];
    ev = '{8'd30, 8'd12, 8'd5, 8'd2, 8'd1};
    do_reset();
    gcycle(1, 8'd1, 0, 8'd0, 0);
    gcycle(1, 8'd40, 0, 8'd0, 0);
    checks++;
    if (state !== 2'd1 || trans_count !== 8'd1) begin
      errs++;
      $display("FAIL conv_start got=%0d/%0d exp=1/1", state, trans_count);
    end
    for (int i = 0; i < 3; i++) gcycle(0, 8'd0, 1, ev[i], 0);
    checks++;
    if (state !== 2'd1) begin
      errs++; $display("FAIL conv_track got=%0d exp=1", state);
    end
    gcycle(0, 8'd0, 1, ev[3], 0);
    checks++;
    if (state !== 2'd2 || lat_valid !== 1'b1 || latency !== 8'd4) begin
      errs++;
      $display("FAIL conv_done got=%0d/%b/%0d exp=2/1/4",
               state, lat_valid, latency);
    end
    @(posedge clk) #1;
    checks++;
    if (lat_valid !== 1'b0 || state !== 2'd0 ||
        hist.hist_data !== 11'h004 || hist.hist_empty !== 1'b0) begin
      errs++;
      $display("FAIL conv_rec got=%b/%0d/%h exp=0/0/004",
               lat_valid, state, hist.hist_data);
    end
    gcycle(0, 8'd0, 1, ev[4], 0);
    pop();
    checks++;
    if (hist.hist_empty !== 1'b1) begin
      errs++; $display("FAIL conv_pop got=%b exp=1", hist.hist_empty);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    gcycle(1, 8'd1, 0, 8'd0, 0);
    gcycle(1, 8'd40, 0, 8'd0, 0);
    for (int i = 0; i < 11; i++) gcycle(0, 8'd0, 1, 8'd20, 0);
    checks++;
    if (state !== 2'd1) begin
      errs++; $display("FAIL to_track got=%0d exp=1", state);
    end
    gcycle(0, 8'd0, 1, 8'd20, 0);
    checks++;
    if (state !== 2'd2 || latency !== 8'd12) begin
      errs++;
      $display("FAIL to_done got=%0d/%0d exp=2/12", state, latency);
    end
    @(posedge clk) #1;
    checks++;
    if (hist.hist_data !== 11'h10C || state !== 2'd0) begin
      errs++;
      $display("FAIL to_rec got=%h/%0d exp=10c/0", hist.hist_data, state);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    gcycle(1, 8'd1, 0, 8'd0, 0);
    gcycle(1, 8'd40, 0, 8'd0, 0);
    gcycle(0, 8'd0, 1, 8'd20, 0);
    gcycle(0, 8'd0, 1, 8'd20, 1);
    gcycle(0, 8'd0, 1, 8'd20, 0);
    gcycle(0, 8'd0, 1, 8'd20, 0);
    gcycle(1, 8'd1, 1, 8'd20, 0);
    checks++;
    if (state !== 2'd2 || latency !== 8'd5 || trans_count !== 8'd2) begin
      errs++;
      $display("FAIL pre_done got=%0d/%0d/%0d exp=2/5/2",
               state, latency, trans_count);
    end
    @(posedge clk) #1;
    checks++;
    if (state !== 2'd1 || hist.hist_data !== 11'h605) begin
      errs++;
      $display("FAIL pre_rec got=%0d/%h exp=1/605", state, hist.hist_data);
    end
    gcycle(0, 8'd0, 1, 8'd0, 0);
    checks++;
    if (state !== 2'd1) begin
      errs++; $display("FAIL pre_restart got=%0d exp=1", state);
    end
    gcycle(0, 8'd0, 1, 8'd0, 0);
    checks++;
    if (state !== 2'd2 || latency !== 8'd2) begin
      errs++;
      $display("FAIL pre_conv got=%0d/%0d exp=2/2", state, latency);
    end
    @(posedge clk) #1;
    pop();
    checks++;
    if (hist.hist_data !== 11'h002 || state !== 2'd0) begin
      errs++;
      $display("FAIL pre_rec2 got=%h/%0d exp=002/0", hist.hist_data, state);
    end
  endtask

  task automatic test_small_jump();
    do_reset();
    gcycle(1, 8'd250, 0, 8'd0, 0);
    gcycle(1, 8'd3, 1, 8'd2, 0);
    checks++;
    if (state !== 2'd0 || trans_count !== 8'd0) begin
      errs++;
      $display("FAIL wrap_nojump got=%0d/%0d exp=0/0", state, trans_count);
    end
    gcycle(1, 8'd40, 0, 8'd0, 0);
    gcycle(0, 8'd0, 1, 8'd2, 0);
    checks++;
    if (state !== 2'd1) begin
      errs++; $display("FAIL minlat_ignore got=%0d exp=1", state);
    end
    gcycle(0, 8'd0, 1, 8'd2, 0);
    checks++;
    if (state !== 2'd2 || latency !== 8'd2) begin
      errs++;
      $display("FAIL minlat_conv got=%0d/%0d exp=2/2", state, latency);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    gcycle(1, 8'd1, 0, 8'd0, 0);
    for (int i = 0; i < 10; i++)
      gcycle(1, (i % 2 == 0) ? 8'd40 : 8'd1, 0, 8'd0, 0);
    @(posedge clk) #1;
    checks++;
    if (hist.hist_full !== 1'b1 || overflow !== 1'b1 ||
        trans_count !== 8'd10) begin
      errs++;
      $display("FAIL ovf got=%b/%b/%0d exp=1/1/10",
               hist.hist_full, overflow, trans_count);
    end
    gcycle(0, 8'd0, 1, 8'd0, 0);
    gcycle(0, 8'd0, 1, 8'd0, 0);
    hist.hist_rd = 1;
    @(posedge clk) #1;
    hist.hist_rd = 0;
    checks++;
    if (hist.hist_full !== 1'b1 || hist.hist_data !== 11'h201) begin
      errs++;
      $display("FAIL full_pp got=%b/%h exp=1/201",
               hist.hist_full, hist.hist_data);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (hist.hist_data !== 11'h201) begin
        errs++;
        $display("FAIL drain%0d got=%h exp=201", i, hist.hist_data);
      end
      pop();
    end
    checks++;
    if (hist.hist_data !== 11'h002 || hist.hist_full !== 1'b0 ||
        hist.hist_empty !== 1'b0) begin
      errs++;
      $display("FAIL pp_tail got=%h/%b/%b exp=002/0/0",
               hist.hist_data, hist.hist_full, hist.hist_empty);
    end
    gcycle(1, 8'd40, 0, 8'd0, 0);
    checks++;
    if (state !== 2'd1) begin
      errs++; $display("FAIL mid_track got=%0d exp=1", state);
    end
    rst_n = 0;
    #2;
    checks++;
    if (hist.hist_empty !== 1'b1 || state !== 2'd0 ||
        overflow !== 1'b0) begin
      errs++;
      $display("FAIL mid_rst got=%b/%0d/%b exp=1/0/0",
               hist.hist_empty, state, overflow);
    end
    rst_n = 1;
  endtask

  initial begin
    hist.hist_rd = 0;
    test_reset();
    test_converge();
    test_timeout();
    test_preempt();
    test_small_jump();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
